miriscv_data_arbiter: RTL

- Two-requester arbiter that shares the SoC data bus between the core data port (m0) and a second master (m1: DMA/debug loader).
- The shared bus feeds the existing address decode into RAM, UART and timer.
- Adds a grant handshake on the requester side and fair round-robin selection.
- Tracks in-order outstanding transactions so each response (rvalid/rdata) returns only to the requester that issued it.

---
 rtl/miriscv_pkg.sv | 19 +
 rtl/miriscv_owner_fifo.sv | 59 +++++
 rtl/miriscv_data_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/miriscv_pkg.sv
// Shared types and constants for the miriscv data-bus arbitration slice.
package miriscv_pkg;

   localparam int XLEN          = 32;
   localparam int ARB_N_MASTERS = 2;

   typedef struct packed {
      logic              we;
      logic [XLEN/8-1:0] be;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   wdata;
   } data_req_t;

   typedef struct packed {
      logic            rvalid;
      logic [XLEN-1:0] rdata;
   } data_rsp_t;

endpackage

// File: rtl/miriscv_owner_fifo.sv
// 1-bit wide in-order FIFO remembering which master issued each outstanding transaction.
module miriscv_owner_fifo #(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          arst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          wdata_i,
   output logic          rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// Round-robin arbiter sharing the SoC data bus between the core (m0) and a second master (m1),
// routing in-order responses back to whichever master issued the transaction.
module miriscv_data_arbiter #(
   parameter int XLEN    = miriscv_pkg::XLEN,
   parameter int MAX_OUT = 2
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              m0_req_i,
   output logic              m0_gnt_o,
   input  logic              m0_we_i,
   input  logic [XLEN/8-1:0] m0_be_i,
   input  logic [XLEN-1:0]   m0_addr_i,
   input  logic [XLEN-1:0]   m0_wdata_i,
   output logic              m0_rvalid_o,
   output logic [XLEN-1:0]   m0_rdata_o,
   input  logic              m1_req_i,
   output logic              m1_gnt_o,
   input  logic              m1_we_i,
   input  logic [XLEN/8-1:0] m1_be_i,
   input  logic [XLEN-1:0]   m1_addr_i,
   input  logic [XLEN-1:0]   m1_wdata_i,
   output logic              m1_rvalid_o,
   output logic [XLEN-1:0]   m1_rdata_o,
   output logic              s_req_o,
   input  logic              s_gnt_i,
   output logic              s_we_o,
   output logic [XLEN/8-1:0] s_be_o,
   output logic [XLEN-1:0]   s_addr_o,
   output logic [XLEN-1:0]   s_wdata_o,
   input  logic              s_rvalid_i,
   input  logic [XLEN-1:0]   s_rdata_i,
   output logic              err_o
);
   import miriscv_pkg::*;

   localparam int CW = $clog2(MAX_OUT + 1);

   data_req_t req_m0, req_m1, req_s;
   data_rsp_t rsp_m0, rsp_m1;

   logic [$clog2(ARB_N_MASTERS)-1:0] sel;
   logic          last_grant_q, last_grant_d;
   logic          err_q, err_d;
   logic          handshake, pop;
   logic          fifo_head, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   assign req_m0 = '{m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i};
   assign req_m1 = '{m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i};

   // Issue is gated by the registered occupancy only, so a same-cycle pop cannot unblock a full FIFO.
   always_comb begin
      sel          = (m0_req_i & m1_req_i) ? ~last_grant_q : m1_req_i;
      s_req_o      = (m0_req_i | m1_req_i) & ~fifo_full & ~arst_i;
      handshake    = s_req_o & s_gnt_i;
      req_s        = (s_req_o & sel[0]) ? req_m1 : req_m0;
      pop          = s_rvalid_i & ~fifo_empty & ~arst_i;
      last_grant_d = handshake ? sel[0] : last_grant_q;
      err_d        = err_q | (s_rvalid_i & (fifo_count == '0));
      rsp_m0       = '{pop & ~fifo_head, s_rdata_i};
      rsp_m1       = '{pop &  fifo_head, s_rdata_i};
   end

   assign s_we_o      = req_s.we;
   assign s_be_o      = req_s.be;
   assign s_addr_o    = req_s.addr;
   assign s_wdata_o   = req_s.wdata;
   assign m0_gnt_o    = handshake & ~sel[0];
   assign m1_gnt_o    = handshake &  sel[0];
   assign m0_rvalid_o = rsp_m0.rvalid;
   assign m0_rdata_o  = rsp_m0.rdata;
   assign m1_rvalid_o = rsp_m1.rvalid;
   assign m1_rdata_o  = rsp_m1.rdata;
   assign err_o       = err_q;

   miriscv_owner_fifo #(.DEPTH(MAX_OUT)) u_owner_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .push_i  (handshake),
      .pop_i   (pop),
      .wdata_i (sel[0]),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Reset value 1 lets m0 win the first contention.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
      end
   end

endmodule
